// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Bundle of pipeline-control outputs, driven as one unit per state/case.
    typedef struct packed {
        logic muxsel;
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
    } ctrl_t;

    localparam ctrl_t RUN_OUTS      = '{muxsel: 1'b0, pc_write: 1'b1, if_id_write: 1'b1,
                                        if_id_flush: 1'b0, id_ex_write: 1'b1};
    localparam ctrl_t BUBBLE_OUTS   = '{muxsel: 1'b1, pc_write: 1'b1, if_id_write: 1'b1,
                                        if_id_flush: 1'b1, id_ex_write: 1'b1};
    localparam ctrl_t FREEZE_OUTS   = '{muxsel: 1'b0, pc_write: 1'b0, if_id_write: 1'b0,
                                        if_id_flush: 1'b0, id_ex_write: 1'b0};
    localparam ctrl_t LOAD_USE_OUTS = '{muxsel: 1'b1, pc_write: 1'b0, if_id_write: 1'b0,
                                        if_id_flush: 1'b0, id_ex_write: 1'b1};
    localparam ctrl_t RESET_OUTS    = '{muxsel: 1'b1, pc_write: 1'b0, if_id_write: 1'b0,
                                        if_id_flush: 1'b1, id_ex_write: 1'b1};

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic load_use(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic use_rs1, input logic use_rs2,
                                      input logic [4:0] rd, input logic mem_read);
        return mem_read && (rd != REG_X0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use bubbles, branch flushes and memory-wait freezes
// for a 5-stage RV32 pipeline, with saturating stall/flush counters.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             muxsel,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FLUSH_W = 3;
    localparam int WAIT_W  = 16;

    state_t              state_q, state_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    ctrl_t               outs;
    logic                lu;
    logic                mem_stall;
    logic                timeout_hit;

    assign lu        = load_use(id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read);
    assign mem_stall = dmem_req && !dmem_ready;

    // Next-state and Mealy control outputs; reset overrides everything.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        flush_d = flush_q;
        wait_d  = wait_q;
        outs    = RUN_OUTS;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    outs    = FREEZE_OUTS;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else if (branch_taken) begin
                    outs = BUBBLE_OUTS;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        flush_d = FLUSH_W'(FLUSH_CYCLES - 1);
                    end
                end else if (lu) begin
                    outs = LOAD_USE_OUTS;
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    // The freeze holds the pipeline, so the pending flush is dropped.
                    outs    = FREEZE_OUTS;
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                    flush_d = '0;
                end else begin
                    outs    = BUBBLE_OUTS;
                    flush_d = flush_q - 1'b1;
                    if (flush_q <= FLUSH_W'(1)) begin
                        state_d = RUN;
                        flush_d = '0;
                    end
                end
            end
            MEM_WAIT: begin
                outs = FREEZE_OUTS;
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (wait_q != WAIT_W'(TIMEOUT)) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst) begin
            outs = RESET_OUTS;
        end
    end

    assign timeout_hit = (state_d == MEM_WAIT) && (wait_d == WAIT_W'(TIMEOUT));

    // State, sequencing counters and the sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_q     <= '0;
            wait_q      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            wait_q      <= wait_d;
            mem_timeout <= mem_timeout || timeout_hit;
        end
    end

    assign muxsel      = outs.muxsel;
    assign pc_write    = outs.pc_write;
    assign if_id_write = outs.if_id_write;
    assign if_id_flush = outs.if_id_flush;
    assign id_ex_write = outs.id_ex_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!outs.pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (outs.if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share the stimulus:
// u_dut (FLUSH_CYCLES=2, TIMEOUT=4, CNT_W=32) and u_sat (FLUSH_CYCLES=1, TIMEOUT=255, CNT_W=3).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       branch_taken, dmem_req, dmem_ready;

    logic        a_muxsel, a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write, a_timeout;
    logic [31:0] a_stall, a_flush;
    logic        b_muxsel, b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write, b_timeout;
    logic [2:0]  b_stall, b_flush;

    // Output bundles ordered {muxsel, pc_write, if_id_write, if_id_flush, id_ex_write}.
    wire [4:0] outs_a = {a_muxsel, a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_write};
    wire [4:0] outs_b = {b_muxsel, b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_write};

    localparam logic [4:0] O_RUN    = 5'b01101;
    localparam logic [4:0] O_BUBBLE = 5'b11111;
    localparam logic [4:0] O_FREEZE = 5'b00000;
    localparam logic [4:0] O_LU     = 5'b10001;
    localparam logic [4:0] O_RESET  = 5'b10011;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       lu;
    } lu_vec_t;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT(4), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .muxsel(a_muxsel), .pc_write(a_pc_write),
        .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush), .id_ex_write(a_id_ex_write),
        .mem_timeout(a_timeout), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(255), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .muxsel(b_muxsel), .pc_write(b_pc_write),
        .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush), .id_ex_write(b_id_ex_write),
        .mem_timeout(b_timeout), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic drive_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_chk++; if (outs_a !== O_RESET) begin n_fail++; $display("FAIL reset_outs_a got %b want %b", outs_a, O_RESET); end
        n_chk++; if (outs_b !== O_RESET) begin n_fail++; $display("FAIL reset_outs_b got %b want %b", outs_b, O_RESET); end
        n_chk++; if (a_stall !== 32'd0 || a_flush !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_a stall %0d flush %0d want 0 0", a_stall, a_flush); end
        n_chk++; if (a_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", a_timeout); end
        rst = 1'b0;
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL reset_release_outs got %b want %b", outs_a, O_RUN); end
        tick();
        #1;
        n_chk++; if (a_stall !== 32'd0 || b_flush !== 3'd0) begin n_fail++; $display("FAIL reset_idle_cnt stall %0d flush %0d want 0 0", a_stall, b_flush); end
    endtask

    task automatic test_load_use();
        lu_vec_t vecs [6];
        int exp_stall;
        vecs[0] = '{rs1: 5'd0, rs2: 5'd5, u1: 1'b0, u2: 1'b1, rd: 5'd5, mr: 1'b1, lu: 1'b1};
        vecs[1] = '{rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b1, rd: 5'd0, mr: 1'b1, lu: 1'b0};
        vecs[2] = '{rs1: 5'd7, rs2: 5'd3, u1: 1'b1, u2: 1'b1, rd: 5'd7, mr: 1'b1, lu: 1'b1};
        vecs[3] = '{rs1: 5'd7, rs2: 5'd3, u1: 1'b0, u2: 1'b1, rd: 5'd7, mr: 1'b1, lu: 1'b0};
        vecs[4] = '{rs1: 5'd9, rs2: 5'd9, u1: 1'b1, u2: 1'b1, rd: 5'd9, mr: 1'b0, lu: 1'b0};
        vecs[5] = '{rs1: 5'd1, rs2: 5'd2, u1: 1'b1, u2: 1'b1, rd: 5'd3, mr: 1'b1, lu: 1'b0};
        do_reset();
        exp_stall = 0;
        for (int i = 0; i < 6; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
            #1;
            n_chk++;
            if (outs_a !== (vecs[i].lu ? O_LU : O_RUN)) begin
                n_fail++; $display("FAIL lu_outs_v%0d got %b want %b", i, outs_a, vecs[i].lu ? O_LU : O_RUN);
            end
            if (vecs[i].lu) exp_stall++;
            tick();
            idle();
            #1;
            n_chk++;
            if (a_stall !== 32'(exp_stall) || outs_a !== O_RUN) begin
                n_fail++; $display("FAIL lu_after_v%0d stall %0d outs %b want %0d %b", i, a_stall, outs_a, exp_stall, O_RUN);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1;
        drive_lu();
        #1;
        n_chk++; if (outs_a !== O_BUBBLE) begin n_fail++; $display("FAIL br_c1_a got %b want %b", outs_a, O_BUBBLE); end
        n_chk++; if (outs_b !== O_BUBBLE) begin n_fail++; $display("FAIL br_c1_b got %b want %b", outs_b, O_BUBBLE); end
        tick();
        idle();
        #1;
        n_chk++; if (outs_a !== O_BUBBLE) begin n_fail++; $display("FAIL br_c2_a got %b want %b", outs_a, O_BUBBLE); end
        n_chk++; if (outs_b !== O_RUN) begin n_fail++; $display("FAIL br_c2_b got %b want %b", outs_b, O_RUN); end
        tick();
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL br_c3_a got %b want %b", outs_a, O_RUN); end
        n_chk++; if (a_flush !== 32'd2 || b_flush !== 3'd1) begin n_fail++; $display("FAIL br_flush_cnt a %0d b %0d want 2 1", a_flush, b_flush); end
        n_chk++; if (a_stall !== 32'd0) begin n_fail++; $display("FAIL br_stall_cnt got %0d want 0", a_stall); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        branch_taken = 1'b1;
        tick();
        #1;
        n_chk++; if (outs_a !== O_BUBBLE || outs_b !== O_BUBBLE) begin n_fail++; $display("FAIL b2b_c2 a %b b %b want %b", outs_a, outs_b, O_BUBBLE); end
        tick();
        idle();
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL b2b_c3 got %b want %b", outs_a, O_RUN); end
        n_chk++; if (a_flush !== 32'd2 || b_flush !== 3'd2) begin n_fail++; $display("FAIL b2b_flush_cnt a %0d b %0d want 2 2", a_flush, b_flush); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        dmem_req = 1'b1;
        dmem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) dmem_ready = 1'b1;
            #1;
            n_chk++;
            if (outs_a !== O_FREEZE) begin n_fail++; $display("FAIL memw_c%0d got %b want %b", c, outs_a, O_FREEZE); end
            tick();
        end
        idle();
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL memw_done got %b want %b", outs_a, O_RUN); end
        n_chk++; if (a_stall !== 32'd4 || b_stall !== 3'd4) begin n_fail++; $display("FAIL memw_stall a %0d b %0d want 4 4", a_stall, b_stall); end
        n_chk++; if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL memw_timeout_b got %b want 0", b_timeout); end
    endtask

    task automatic test_flush_mem();
        do_reset();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        dmem_req = 1'b1;
        #1;
        n_chk++; if (outs_a !== O_FREEZE) begin n_fail++; $display("FAIL flmem_freeze got %b want %b", outs_a, O_FREEZE); end
        tick();
        dmem_ready = 1'b1;
        #1;
        n_chk++; if (outs_a !== O_FREEZE) begin n_fail++; $display("FAIL flmem_wait got %b want %b", outs_a, O_FREEZE); end
        tick();
        idle();
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL flmem_run got %b want %b", outs_a, O_RUN); end
        n_chk++; if (a_flush !== 32'd1) begin n_fail++; $display("FAIL flmem_flush_cnt got %0d want 1", a_flush); end
    endtask

    task automatic test_timeout();
        do_reset();
        dmem_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_chk++;
            if (a_timeout !== (k >= 4)) begin n_fail++; $display("FAIL tmo_k%0d got %b want %b", k, a_timeout, k >= 4); end
        end
        dmem_ready = 1'b1;
        tick();
        idle();
        tick();
        n_chk++; if (a_timeout !== 1'b1 || outs_a !== O_RUN) begin n_fail++; $display("FAIL tmo_sticky timeout %b outs %b want 1 %b", a_timeout, outs_a, O_RUN); end
        n_chk++; if (b_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_b got %b want 0", b_timeout); end
        rst = 1'b1;
        #1;
        n_chk++; if (a_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared got %b want 0", a_timeout); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dmem_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_chk++; if (outs_a !== O_RESET || a_stall !== 32'd0) begin n_fail++; $display("FAIL rmid_wait outs %b stall %0d want %b 0", outs_a, a_stall, O_RESET); end
        tick();
        idle();
        rst = 1'b0;
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL rmid_wait_release got %b want %b", outs_a, O_RUN); end
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++; if (outs_a !== O_RESET || a_flush !== 32'd0) begin n_fail++; $display("FAIL rmid_flush outs %b flush %0d want %b 0", outs_a, a_flush, O_RESET); end
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (outs_a !== O_RUN) begin n_fail++; $display("FAIL rmid_flush_release got %b want %b", outs_a, O_RUN); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive_lu();
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 7) begin
                n_chk++; if (b_stall !== 3'd7) begin n_fail++; $display("FAIL sat_at7 got %0d want 7", b_stall); end
            end
        end
        idle();
        #1;
        n_chk++; if (b_stall !== 3'd7) begin n_fail++; $display("FAIL sat_b got %0d want 7", b_stall); end
        n_chk++; if (a_stall !== 32'd10) begin n_fail++; $display("FAIL sat_a got %0d want 10", a_stall); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_flush_mem();
        test_timeout();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
